// File: rtl/logic_seq_pkg.sv
// Shared definitions for the multi-cycle logic unit: opcode encoding and FSM states.
package logic_seq_pkg;

  // Logic opcodes as presented on the op input.
  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/logic_slice.sv
// Combinational STEP-bit logic operation; applied to the low slice of the operand registers.
module logic_slice
  import logic_seq_pkg::*;
#(
  parameter int unsigned STEP = 1
) (
  input  logic [STEP-1:0] a,
  input  logic [STEP-1:0] b,
  input  logic [1:0]      op,
  output logic [STEP-1:0] y
);

  // Per-bit operation selected by opcode; NOR is simply the inverse of OR.
  always_comb begin
    y = '0;
    unique case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOR:  y = ~(a | b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_seq32.sv
// Multi-cycle bitwise logic unit: processes STEP bits per cycle, LSB first, and publishes the
// result on S with a one-cycle done strobe.
// Optional feature: define LOGIC_ZERO_FLAG_EN to add a registered zero flag (S == 0).
module logic_seq32
  import logic_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S
`ifdef LOGIC_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam int unsigned SLICES = WIDTH / STEP;
  // Keep the counter at least one bit wide for the degenerate single-slice case.
  localparam int unsigned CNTW = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(SLICES - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef LOGIC_ZERO_FLAG_EN
  logic             zero_q, zero_d;
`endif
  logic [STEP-1:0]  slice_res;

  logic_slice #(
    .STEP (STEP)
  ) u_slice (
    .a  (a_q[STEP-1:0]),
    .b  (b_q[STEP-1:0]),
    .op (op_q),
    .y  (slice_res)
  );

  // Next-state logic for the controller, datapath shift registers and output registers.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    part_d  = part_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
`ifdef LOGIC_ZERO_FLAG_EN
    zero_d  = zero_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_d     = A;
          b_d     = B;
          op_d    = op;
          part_d  = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end

      RUN: begin
        // New slice enters at the MSB end so the first (lowest) slice ends up at bit 0.
        part_d                   = part_q >> STEP;
        part_d[WIDTH-1 -: STEP]  = slice_res;
        a_d                      = a_q >> STEP;
        b_d                      = b_q >> STEP;
        if (cnt_q == CNT_LAST) begin
          // Counter holds on the final slice; leaving RUN makes wrap impossible.
          state_d = DONE;
          busy_d  = 1'b0;
        end else begin
          cnt_d  = cnt_q + CNTW'(1);
          busy_d = 1'b1;
        end
      end

      DONE: begin
        // Whole result is published at once; S never shows a partial value.
        s_d     = part_q;
        done_d  = 1'b1;
        state_d = IDLE;
`ifdef LOGIC_ZERO_FLAG_EN
        zero_d  = (part_q == '0);
`endif
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset; reset also discards any result in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_AND;
      part_q  <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef LOGIC_ZERO_FLAG_EN
      zero_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      part_q  <= part_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef LOGIC_ZERO_FLAG_EN
      zero_q  <= zero_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign S    = s_q;
`ifdef LOGIC_ZERO_FLAG_EN
  assign zero = zero_q;
`endif

endmodule

// File: tb/tb_logic_seq32.sv
// Self-checking bench for logic_seq32 (STEP=1 instance plus a STEP=4 instance).
module tb_logic_seq32;

  localparam int unsigned SL1 = 32;
  localparam int unsigned SL4 = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start4;
  logic [1:0]  op, op4;
  logic [31:0] a, b, a4, b4;
  logic        busy, done, busy4, done4;
  logic [31:0] s, s4;
`ifdef LOGIC_ZERO_FLAG_EN
  logic        zero, zero4;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  logic_seq32 #(
    .WIDTH (32),
    .STEP  (1)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .A     (a),
    .B     (b),
    .busy  (busy),
    .done  (done),
    .S     (s)
`ifdef LOGIC_ZERO_FLAG_EN
    ,
    .zero  (zero)
`endif
  );

  logic_seq32 #(
    .WIDTH (32),
    .STEP  (4)
  ) dut4 (
    .clk   (clk),
    .rst   (rst),
    .start (start4),
    .op    (op4),
    .A     (a4),
    .B     (b4),
    .busy  (busy4),
    .done  (done4),
    .S     (s4)
`ifdef LOGIC_ZERO_FLAG_EN
    ,
    .zero  (zero4)
`endif
  );

  // Whole-word reference: 00 AND, 01 OR, 10 XOR, 11 NOR.
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    case (o)
      2'd0:    return x & y;
      2'd1:    return x | y;
      2'd2:    return x ^ y;
      default: return ~(x | y);
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge, then scramble the inputs to prove they are not reused.
  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    step();
    start = 1'b0;
    op    = 2'($urandom);
    a     = $urandom;
    b     = $urandom;
  endtask

  // Wait (bounded) for done; measures latency, busy cycles, busy/done overlap and early S change.
  task automatic wait_done(input logic [31:0] hold, output int lat, output int busy_cyc,
                           output int overlaps, output int s_changes);
    lat       = 0;
    busy_cyc  = (busy === 1'b1) ? 1 : 0;
    overlaps  = 0;
    s_changes = (s !== hold) ? 1 : 0;
    while (done !== 1'b1 && lat < 100) begin
      step();
      lat++;
      if (busy === 1'b1) busy_cyc++;
      if (busy === 1'b1 && done === 1'b1) overlaps++;
      if (done !== 1'b1 && s !== hold) s_changes++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0; op = 2'd0; a = '0; b = '0;
    start4 = 1'b0; op4 = 2'd0; a4 = '0; b4 = '0;
    step();
    step();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++;
    if (s !== 32'h0) begin failures++; $display("FAIL reset_s got=%h exp=0", s); end
`ifdef LOGIC_ZERO_FLAG_EN
    checks++;
    if (zero !== 1'b1) begin failures++; $display("FAIL reset_zero got=%b exp=1", zero); end
`endif
    rst = 1'b0;
    step();
  endtask

  task automatic test_or_timing();
    int lat, bc, ov, sc;
    logic [31:0] exp;
    exp = 32'h00FFFFFF;
    launch(2'd1, 32'h0000FFFF, 32'h00FF00FF);
    wait_done(32'h0, lat, bc, ov, sc);
    checks++;
    if (s !== exp) begin failures++; $display("FAIL or_result got=%h exp=%h", s, exp); end
    checks++;
    if (lat != SL1 + 1) begin failures++; $display("FAIL or_latency got=%0d exp=%0d", lat, SL1 + 1); end
    checks++;
    if (bc != SL1) begin failures++; $display("FAIL or_busy_cycles got=%0d exp=%0d", bc, SL1); end
    checks++;
    if (ov != 0) begin failures++; $display("FAIL or_busy_done_overlap got=%0d exp=0", ov); end
    step();
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL or_done_width got=%b exp=0", done); end
  endtask

  task automatic test_back_to_back();
    int lat, bc, ov, sc;
    launch(2'd0, 32'hF0F0F0F0, 32'hFF00FF00);
    wait_done(32'h00FFFFFF, lat, bc, ov, sc);
    checks++;
    if (s !== 32'hF000F000) begin failures++; $display("FAIL and_result got=%h exp=F000F000", s); end
    // Re-assert start in the cycle right after done.
    launch(2'd2, 32'hFFFFFFFF, 32'h12345678);
    wait_done(32'hF000F000, lat, bc, ov, sc);
    checks++;
    if (sc != 0) begin failures++; $display("FAIL b2b_s_hold got=%0d changes exp=0", sc); end
    checks++;
    if (lat != SL1 + 1) begin failures++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, SL1 + 1); end
    checks++;
    if (s !== 32'hEDCBA987) begin failures++; $display("FAIL xor_result got=%h exp=EDCBA987", s); end
  endtask

  task automatic test_nor_zero();
    int lat, bc, ov, sc;
    launch(2'd3, 32'h0, 32'h0);
    wait_done(32'hEDCBA987, lat, bc, ov, sc);
    checks++;
    if (s !== 32'hFFFFFFFF) begin failures++; $display("FAIL nor_result got=%h exp=FFFFFFFF", s); end
`ifdef LOGIC_ZERO_FLAG_EN
    checks++;
    if (zero !== 1'b0) begin failures++; $display("FAIL nor_zero got=%b exp=0", zero); end
`endif
    launch(2'd0, 32'hAAAAAAAA, 32'h55555555);
    wait_done(32'hFFFFFFFF, lat, bc, ov, sc);
    checks++;
    if (s !== 32'h0) begin failures++; $display("FAIL and_zero_result got=%h exp=0", s); end
`ifdef LOGIC_ZERO_FLAG_EN
    checks++;
    if (zero !== 1'b1) begin failures++; $display("FAIL and_zero_flag got=%b exp=1", zero); end
`endif
  endtask

  task automatic test_ignored_start();
    int lat, bc, ov, sc;
    logic [31:0] exp;
    exp = model(2'd1, 32'h12345678, 32'h0F0F0000);
    launch(2'd1, 32'h12345678, 32'h0F0F0000);
    repeat (9) step();
    start = 1'b1; op = 2'd0; a = 32'hDEADBEEF; b = 32'h0000FFFF;
    step();
    start = 1'b0;
    wait_done(32'h0, lat, bc, ov, sc);
    checks++;
    if (s !== exp) begin failures++; $display("FAIL ignored_start_result got=%h exp=%h", s, exp); end
    checks++;
    if (lat != SL1 + 1 - 10) begin failures++; $display("FAIL ignored_start_latency got=%0d exp=%0d", lat, SL1 - 9); end
  endtask

  task automatic test_reset_mid();
    int lat, bc, ov, sc, dones;
    launch(2'd2, 32'hCAFEF00D, 32'h0F0F0F0F);
    repeat (15) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    checks++;
    if (s !== 32'h0) begin failures++; $display("FAIL midrst_s got=%h exp=0", s); end
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1 || busy === 1'b1) dones++;
      step();
    end
    checks++;
    if (dones != 0) begin failures++; $display("FAIL midrst_no_done got=%0d active cycles exp=0", dones); end
    launch(2'd1, 32'h0000FFFF, 32'h00FF00FF);
    wait_done(32'h0, lat, bc, ov, sc);
    checks++;
    if (s !== 32'h00FFFFFF) begin failures++; $display("FAIL midrst_recover got=%h exp=00FFFFFF", s); end
  endtask

  task automatic test_random();
    int lat, bc, ov, sc;
    logic [1:0]  o;
    logic [31:0] x, y, exp, prev;
    prev = s;
    for (int i = 0; i < 20; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      if (i % 5 == 0) begin o = 2'd0; y = ~x; end
      exp = model(o, x, y);
      launch(o, x, y);
      wait_done(prev, lat, bc, ov, sc);
      checks++;
      if (s !== exp || lat != SL1 + 1 || sc != 0 || ov != 0) begin
        failures++;
        $display("FAIL random[%0d] op=%0d got=%h exp=%h lat=%0d chg=%0d ovl=%0d", i, o, s, exp,
                 lat, sc, ov);
      end
`ifdef LOGIC_ZERO_FLAG_EN
      checks++;
      if (zero !== (exp == 32'h0)) begin
        failures++;
        $display("FAIL random_zero[%0d] got=%b exp=%b", i, zero, (exp == 32'h0));
      end
`endif
      prev = exp;
    end
  endtask

  task automatic test_step4();
    int lat;
    logic [1:0]  o;
    logic [31:0] x, y, exp;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin
        o = 2'd1; x = 32'h80000001; y = 32'h7FFFFFFE;
      end else begin
        o = 2'($urandom_range(0, 3)); x = $urandom; y = $urandom;
      end
      exp = model(o, x, y);
      start4 = 1'b1; op4 = o; a4 = x; b4 = y;
      step();
      start4 = 1'b0; a4 = $urandom; b4 = $urandom;
      lat = 0;
      while (done4 !== 1'b1 && lat < 50) begin
        step();
        lat++;
      end
      checks++;
      if (s4 !== exp || lat != SL4 + 1) begin
        failures++;
        $display("FAIL step4[%0d] got=%h exp=%h lat=%0d exp_lat=%0d", i, s4, exp, lat, SL4 + 1);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_or_timing();
    test_back_to_back();
    test_nor_zero();
    test_ignored_start();
    test_reset_mid();
    test_random();
    test_step4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/logic_seq32.md
# logic_seq32

Multi-cycle bitwise logic unit for the lab datapath, the sequential counterpart to the single-cycle 32-bit gate-level logic blocks. It accepts two operands and a logic opcode on a start pulse and processes STEP bits per cycle, LSB first. It presents the result on S with a one-cycle done strobe. The controller uses it for logic instructions in the multi-cycle CPU.

## Interface
- WIDTH, 32: operand and result width; must be a multiple of STEP.
- STEP, 1: bits processed per cycle; legal values are 1, 2, 4 and 8.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- op  input  2  00 AND, 01 OR, 10 XOR, 11 NOR.
- A  input  WIDTH  operand A; captured when start is accepted.
- B  input  WIDTH  operand B; captured when start is accepted.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle strobe when S is updated.
- S  output  WIDTH  result register.
- zero  output  1  S == 0. Present only with LOGIC_ZERO_FLAG_EN.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE to RUN when start=1:
  - Latch A, B and op into internal registers.
  - Clear the partial-result shift register.
  - Set cnt=0.
- RUN, each cycle:
  - Apply op to the low STEP bits of the latched A and B.
  - Shift the STEP result bits into the partial register from the MSB end.
  - Shift the latched A and B right by STEP.
  - Increment cnt.
- RUN to DONE when cnt == WIDTH/STEP-1, in the same cycle as the last slice.
- DONE:
  - S is loaded from the completed partial register.
  - done=1 for exactly this cycle.
  - Next state is IDLE unconditionally.
- start is ignored in RUN and DONE. It is not queued; back-to-back requests need one IDLE cycle.
- A, B and op may change freely after acceptance without affecting the result.
- S holds its value until the next DONE. S is never partially updated.
- cnt width is clog2(WIDTH/STEP). No wrap-around occurs, because the final count value exits RUN.
- NOR is computed per bit as the inverse of OR, with no special cases.

## Timing
- Reset values: busy=0, done=0, S=0, zero=1 (when present), state=IDLE, cnt=0.
- Reset asserted mid-operation aborts the computation on the next edge:
  - S is forced to 0 and the result is discarded.
  - No done pulse is produced.
- Let edge 0 be the edge where start is accepted. Then:
  - busy is high for WIDTH/STEP cycles, from after edge 0 through edge WIDTH/STEP.
  - done and the new S appear after edge WIDTH/STEP+1.
- With the defaults: busy is high for 32 cycles, done arrives 33 cycles after acceptance, and a new start is accepted 34 cycles after the previous one.
- busy and done are never high simultaneously.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- LOGIC_ZERO_FLAG_EN defined:
  - Adds a registered zero output.
  - zero is updated together with S in DONE and resets to 1.
- LOGIC_ZERO_FLAG_EN undefined: the zero port and its register do not exist. All other behaviour is identical.

## Structure
- Shared package logic_seq_pkg contains:
  - op encoding constants OP_AND, OP_OR, OP_XOR, OP_NOR;
  - the FSM state encoding (IDLE, RUN, DONE) as a typedef.
- One sub-module, logic_slice:
  - Purely combinational.
  - Takes STEP-bit a, b and 2-bit op; produces the STEP-bit result.
  - Instantiated once, on the low slice.
- The FSM, counter, operand shift registers and result register live in logic_seq32.

## Test plan
- OR, A=0x0000FFFF, B=0x00FF00FF -> S=0x00FFFFFF, with done exactly 33 cycles after start and busy high for 32 cycles.
- AND 0xF0F0F0F0 & 0xFF00FF00 -> 0xF000F000. Then XOR 0xFFFFFFFF ^ 0x12345678 -> 0xEDCBA987. Start is re-asserted on the cycle after done, and S holds 0xF000F000 until the second done.
- NOR, A=0, B=0 -> 0xFFFFFFFF. With the macro: AND 0xAAAAAAAA & 0x55555555 -> S=0, zero=1; the prior NOR result gives zero=0.
- Start pulsed again with different operands at cycle 10 of a run -> ignored; the original result is delivered at cycle 33. Operands changed after acceptance also have no effect.
- rst asserted at cycle 15 of a run -> next edge gives busy=0, S=0, IDLE; no done pulse follows. A fresh OR completes correctly afterwards.
- STEP=4 build: OR 0x80000001 | 0x7FFFFFFE -> 0xFFFFFFFF, with done 9 cycles after start.
